// File: rtl/bimodal_btb_predictor.sv
// bimodal_btb_predictor: direct-mapped BTB with 2-bit counters, optional same-cycle bypass via BP_BYPASS_EN
module bimodal_btb_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [63:0] upd_pred_target,
  output logic        mispredict,
  output logic [63:0] redirect_pc
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [63:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [IDX_W-1:0] w_if_idx, w_upd_idx;
  logic [TAG_W-1:0] w_if_tag, w_upd_tag;
  logic             w_upd_hit, w_upd_we, w_byp, w_lk_hit;
  logic [1:0]       w_cur_ctr, w_new_ctr, w_lk_ctr;
  logic [63:0]      w_new_tgt, w_lk_tgt, w_redirect;
  logic             w_unused;
  assign w_if_idx  = if_pc[IDX_W+1:2];
  assign w_if_tag  = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_unused  = ^{if_pc, upd_pc};
  // training: hit adjusts the counter, a taken miss allocates with weakly-taken, a not-taken miss writes nothing
  always_comb begin
    w_cur_ctr = r_ctr[w_upd_idx];
    w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    w_upd_we  = upd_valid && (w_upd_hit || upd_taken);
    w_new_ctr = !w_upd_hit ? 2'b10 :
                upd_taken  ? ((w_cur_ctr == 2'b11) ? 2'b11 : w_cur_ctr + 2'd1) :
                             ((w_cur_ctr == 2'b00) ? 2'b00 : w_cur_ctr - 2'd1);
    w_new_tgt = upd_taken ? upd_target : r_target[w_upd_idx];
  end
`ifdef BP_BYPASS_EN
  assign w_byp = reset && w_upd_we && (w_upd_idx == w_if_idx) && (w_upd_tag == w_if_tag);
`else
  assign w_byp = 1'b0;
`endif
  // lookup reads the stored entry, or the entry being written this cycle when bypassing
  always_comb begin
    w_lk_hit    = w_byp || (r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag));
    w_lk_ctr    = w_byp ? w_new_ctr : r_ctr[w_if_idx];
    w_lk_tgt    = w_byp ? w_new_tgt : r_target[w_if_idx];
    pred_hit    = reset && w_lk_hit;
    pred_taken  = reset && w_lk_hit && w_lk_ctr[1];
    pred_target = !reset ? 64'd0 : pred_taken ? w_lk_tgt : if_pc + 64'd4;
  end
  // resolution side: correct next PC and mispredict flag, both silenced during reset
  always_comb begin
    w_redirect  = upd_taken ? upd_target : upd_pc + 64'd4;
    redirect_pc = reset ? w_redirect : 64'd0;
    mispredict  = reset && upd_valid &&
                  ((upd_taken != upd_pred_taken) || (w_redirect != upd_pred_target));
  end
  // table state: reset invalidates everything and drops any concurrent update
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_upd_we) begin
      r_valid[w_upd_idx]  <= 1'b1;
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= w_new_tgt;
      r_ctr[w_upd_idx]    <= w_new_ctr;
    end
  end
endmodule
